// File: rtl/stream_xor_cipher_if.sv
// stream_xor_cipher_if
//   Bundle of every stream_xor_cipher signal other than clk/rst: the key
//   control inputs, the input and output valid/ready word channels, and the
//   status outputs.
//   slave  = view of the cipher block itself.
//   master = view of whatever drives the block (front end plus sink).
//   Build option: STREAM_XOR_PARITY_EN adds the out_parity signal.
interface stream_xor_cipher_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
);

  // Key control
  logic              key_load;
  logic [DATA_W-1:0] key_in;
  logic              key_clear;

  // Input word channel
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  // Output word channel
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef STREAM_XOR_PARITY_EN
  logic              out_parity;
`endif

  // Status
  logic [CNT_W-1:0]  word_cnt;
  logic              keyed;

  modport slave (
    input  key_load,
    input  key_in,
    input  key_clear,
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data,
`ifdef STREAM_XOR_PARITY_EN
    output out_parity,
`endif
    output word_cnt,
    output keyed
  );

  modport master (
    output key_load,
    output key_in,
    output key_clear,
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data,
`ifdef STREAM_XOR_PARITY_EN
    input  out_parity,
`endif
    input  word_cnt,
    input  keyed
  );

endinterface

// File: rtl/stream_xor_cipher.sv
// stream_xor_cipher
//   Clocked stream XOR cipher. Each accepted DATA_W-bit word is XORed with a
//   rolling key, which then rotates left by ROT_STEP mod DATA_W bits. The
//   result is held in a single registered output stage behind a valid/ready
//   handshake. Because the operation is symmetric, the same block reloaded
//   with the same key decrypts its own output.
//   Control: IDLE (no key, input closed) / RUN (keyed, input open).
//   Build option: STREAM_XOR_PARITY_EN adds out_parity (even parity of
//   out_data), registered alongside out_data.
//   Parameters: DATA_W must be >= 2; ROT_STEP mod DATA_W == 0 gives a fixed
//   key, which is the legacy encoder behaviour.
module stream_xor_cipher #(
  parameter int DATA_W   = 4,
  parameter int ROT_STEP = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  stream_xor_cipher_if.slave  bus
);

  // Effective rotate amount; a multiple of DATA_W reduces to no rotation.
  localparam int ROT_AMT = ROT_STEP % DATA_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Rotate a key left by ROT_AMT bits. ROT_AMT == 0 returns the key
  // unchanged.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v);
    if (ROT_AMT == 0) begin
      return v;
    end
    return (v << ROT_AMT) | (v >> (DATA_W - ROT_AMT));
  endfunction

  state_e             r_state;
  state_e             w_state_nxt;
  logic [DATA_W-1:0]  r_key;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_word_cnt;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_keyed;
  logic [DATA_W-1:0]  w_cipher;

  // NOTE: state registers use non-blocking assignments. All flops then
  // update together at the clock edge, so no read order between blocks can
  // make one register see another register's new value.
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal written here is given a default before the case
  // statement. A path that leaves a signal unassigned would infer a latch.
  // Next-state and handshake decode. key_clear wins over key_load.
  always_comb begin
    w_state_nxt = r_state;
    w_keyed     = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.key_clear && bus.key_load) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_keyed    = 1'b1;
        // Open for a word when the output stage is empty or draining now.
        w_in_ready = ~r_out_valid | bus.out_ready;
        if (bus.key_clear) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_cipher = bus.in_data ^ r_key;

  // Key register. A load or clear replaces the key outright. In the same
  // cycle as an accept, the word has already used the old key, so the
  // rotation is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key <= '0;
    end else if (bus.key_clear) begin
      r_key <= '0;
    end else if (bus.key_load) begin
      r_key <= bus.key_in;
    end else if (w_accept) begin
      r_key <= rotl(r_key);
    end
  end

  // Accepted-word counter. It restarts at every key change and wraps
  // silently at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_cnt <= '0;
    end else if (bus.key_clear || bus.key_load) begin
      r_word_cnt <= '0;
    end else if (w_accept) begin
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  // Output stage. It captures the ciphered word on accept and otherwise
  // holds until the sink takes it. A pending word survives key_clear and
  // key_load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_cipher;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef STREAM_XOR_PARITY_EN
  logic r_out_parity;

  // Parity of the captured word, loaded and held exactly like out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_parity <= 1'b0;
    end else if (w_accept) begin
      r_out_parity <= ^w_cipher;
    end
  end

  assign bus.out_parity = r_out_parity;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.word_cnt  = r_word_cnt;
  assign bus.keyed     = w_keyed;

endmodule

// File: tb/tb_stream_xor_cipher.sv
// tb_stream_xor_cipher
//   Bench for stream_xor_cipher (DATA_W=4, ROT_STEP=1), with a second
//   instance at ROT_STEP=0 for the fixed-key case. Every accepted word pushes
//   its expected ciphertext, taken from a reference key model, onto a
//   scoreboard queue. A negedge monitor pops the queue and compares it
//   against each word the sink takes.
module tb_stream_xor_cipher;

  localparam int DW = 4;
  localparam int CW = 16;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] m_key;
  int            m_cnt;

  stream_xor_cipher_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
  stream_xor_cipher_if #(.DATA_W(DW), .CNT_W(CW)) bus0 ();

  stream_xor_cipher #(.DATA_W(DW), .ROT_STEP(1), .CNT_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  stream_xor_cipher #(.DATA_W(DW), .ROT_STEP(0), .CNT_W(CW)) u_dut_fixed (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rotate-left, written as a bit scatter.
  function automatic logic [DW-1:0] m_rotl(input logic [DW-1:0] k, input int s);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i++) begin
      r[(i + s) % DW] = k[i];
    end
    return r;
  endfunction

  // Scoreboard monitor: a transfer completes at the next edge whenever
  // out_valid and out_ready are both high at the negedge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      logic [DW-1:0] exp_w;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h, expected no output word", bus.out_data);
      end else begin
        exp_w = sb_q.pop_front();
        if (bus.out_data !== exp_w) begin
          errors++;
          $display("FAIL out_data: got %h, expected %h", bus.out_data, exp_w);
        end
`ifdef STREAM_XOR_PARITY_EN
        checks++;
        if (bus.out_parity !== ^exp_w) begin
          errors++;
          $display("FAIL out_parity: got %b, expected %b", bus.out_parity, ^exp_w);
        end
`endif
      end
    end
  end

  // Drives one cycle of inputs at posedge+1. At the following negedge it
  // records any accept in the scoreboard and advances the reference key
  // model.
  task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic r,
                             input logic kl = 1'b0, input logic [DW-1:0] ki = '0,
                             input logic kc = 1'b0);
    logic acc;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.key_load  = kl;
    bus.key_in    = ki;
    bus.key_clear = kc;
    @(negedge clk);
    acc = v && (bus.in_ready === 1'b1);
    if (acc) sb_q.push_back(d ^ m_key);
    if (kc) begin
      m_key = '0;
      m_cnt = 0;
    end else if (kl) begin
      m_key = ki;
      m_cnt = 0;
    end else if (acc) begin
      m_key = m_rotl(m_key, 1);
      m_cnt++;
    end
  endtask

  // Lets the output drain with bounded patience.
  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words still expected, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus.key_load = 0; bus.key_in = '0; bus.key_clear = 0;
    bus0.in_valid = 0; bus0.in_data = '0; bus0.out_ready = 0;
    bus0.key_load = 0; bus0.key_in = '0; bus0.key_clear = 0;
    m_key = '0; m_cnt = 0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.out_data !== 4'h0) begin errors++; $display("FAIL rst_out_data: got %h, expected 0", bus.out_data); end
    if (bus.keyed !== 1'b0) begin errors++; $display("FAIL rst_keyed: got %b, expected 0", bus.keyed); end
    if (bus.word_cnt !== 16'd0) begin errors++; $display("FAIL rst_word_cnt: got %0d, expected 0", bus.word_cnt); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, expected 0", bus.in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_no_key();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 4'h3, 1'b1);
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL nokey_in_ready: got %b, expected 0", bus.in_ready); end
    end
    drive_cycle(1'b0, '0, 1'b1);
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL nokey_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.word_cnt !== 16'd0) begin errors++; $display("FAIL nokey_word_cnt: got %0d, expected 0", bus.word_cnt); end
  endtask

  task automatic test_encrypt();
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 4'b1001);
    drive_cycle(1'b1, 4'h3, 1'b1);
    checks++;
    if (bus.keyed !== 1'b1) begin errors++; $display("FAIL enc_keyed: got %b, expected 1", bus.keyed); end
    drive_cycle(1'b1, 4'h3, 1'b1);
    drive_cycle(1'b1, 4'h3, 1'b1);
    drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (bus.word_cnt !== 16'd3) begin errors++; $display("FAIL enc_word_cnt: got %0d, expected 3", bus.word_cnt); end
    drain();
  endtask

  task automatic test_decrypt();
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 4'b1001);
    drive_cycle(1'b1, 4'hA, 1'b1);
    checks++;
    if (bus.word_cnt !== 16'd0) begin errors++; $display("FAIL dec_cnt_reload: got %0d, expected 0", bus.word_cnt); end
    drive_cycle(1'b1, 4'h0, 1'b1);
    drive_cycle(1'b1, 4'h5, 1'b1);
    drive_cycle(1'b0, '0, 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 4'b1001);
    drive_cycle(1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 4'h3, 1'b0);
      checks += 3;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, expected 0", bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, expected 1", bus.out_valid); end
      if (bus.out_data !== 4'hA) begin errors++; $display("FAIL bp_out_data: got %h, expected a", bus.out_data); end
    end
    drive_cycle(1'b1, 4'h3, 1'b1);
    drive_cycle(1'b1, 4'h3, 1'b1);
    drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (bus.word_cnt !== 16'd3) begin errors++; $display("FAIL bp_word_cnt: got %0d, expected 3", bus.word_cnt); end
    drain();
  endtask

  task automatic test_load_with_accept();
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 4'b1001);
    drive_cycle(1'b1, 4'h3, 1'b1);
    drive_cycle(1'b1, 4'h3, 1'b1);
    drive_cycle(1'b1, 4'hF, 1'b1, 1'b1, 4'b0001);
    drive_cycle(1'b1, 4'h0, 1'b1);
    checks++;
    if (bus.out_data !== 4'h9) begin errors++; $display("FAIL ldacc_out_data: got %h, expected 9", bus.out_data); end
    drive_cycle(1'b0, '0, 1'b1);
    checks += 2;
    if (bus.out_data !== 4'h1) begin errors++; $display("FAIL ldacc_next_data: got %h, expected 1", bus.out_data); end
    if (bus.word_cnt !== 16'd1) begin errors++; $display("FAIL ldacc_word_cnt: got %0d, expected 1", bus.word_cnt); end
    drain();
  endtask

  task automatic test_key_clear();
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 4'b1001);
    drive_cycle(1'b1, 4'h3, 1'b1);
    drive_cycle(1'b1, 4'h3, 1'b1, 1'b0, '0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0);
    checks += 5;
    if (bus.keyed !== 1'b0) begin errors++; $display("FAIL clr_keyed: got %b, expected 0", bus.keyed); end
    if (bus.word_cnt !== 16'd0) begin errors++; $display("FAIL clr_word_cnt: got %0d, expected 0", bus.word_cnt); end
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clr_pending_valid: got %b, expected 1", bus.out_valid); end
    if (bus.out_data !== 4'h0) begin errors++; $display("FAIL clr_pending_data: got %h, expected 0", bus.out_data); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready: got %b, expected 0", bus.in_ready); end
    drive_cycle(1'b1, 4'h3, 1'b1);
    drive_cycle(1'b0, '0, 1'b1);
    drain();
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 4'b0110);
    drive_cycle(1'b1, 4'h7, 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.keyed !== 1'b0) begin errors++; $display("FAIL arst_keyed: got %b, expected 0", bus.keyed); end
    if (bus.word_cnt !== 16'd0) begin errors++; $display("FAIL arst_word_cnt: got %0d, expected 0", bus.word_cnt); end
    if (bus.out_data !== 4'h0) begin errors++; $display("FAIL arst_out_data: got %h, expected 0", bus.out_data); end
    sb_q.delete();
    m_key = '0;
    m_cnt = 0;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fixed_key();
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.key_load = 1'b1;
    bus0.key_in   = 4'h5;
    for (int i = 0; i <= 4; i++) begin
      logic [DW-1:0] di;
      logic [DW-1:0] exp_w;
      @(posedge clk);
      #1;
      di = DW'(i);
      bus0.key_load = 1'b0;
      bus0.in_valid = (i < 4);
      bus0.in_data  = di;
      @(negedge clk);
      if (i > 0) begin
        exp_w = DW'(i - 1) ^ 4'h5;
        checks += 2;
        if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL fix_out_valid: got %b, expected 1", bus0.out_valid); end
        if (bus0.out_data !== exp_w) begin errors++; $display("FAIL fix_out_data: got %h, expected %h", bus0.out_data, exp_w); end
      end
    end
    @(negedge clk);
    checks += 2;
    if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL fix_drained: got %b, expected 0", bus0.out_valid); end
    if (bus0.word_cnt !== 16'd4) begin errors++; $display("FAIL fix_word_cnt: got %0d, expected 4", bus0.word_cnt); end
  endtask

  initial begin
    test_reset();
    test_no_key();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_load_with_accept();
    test_key_clear();
    test_async_reset();
    test_encrypt();
    test_fixed_key();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d words still expected, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
